// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, state encoding and key helpers for the keypad scanner
package keypad_pkg;

    localparam logic [15:0] KEY_IDLE      = 16'h00FF;
    localparam int          KEY_VALID_BIT = 15;
    localparam int          CODE_W        = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Key code = row*4 + lowest-indexed low column; lowest code wins on multi-press.
    function automatic logic [CODE_W-1:0] key_code(input logic [1:0] row, input logic [3:0] col);
        logic [1:0] c;
        c = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) c = i[1:0];
        end
        return {row, c};
    endfunction

    // Strobe word: valid marker in bit 15, code in the low nibble, zeros elsewhere.
    function automatic logic [15:0] key_strobe(input logic [CODE_W-1:0] code);
        logic [15:0] v;
        v                = 16'h0000;
        v[KEY_VALID_BIT] = 1'b1;
        v[CODE_W-1:0]    = code;
        return v;
    endfunction

    // Active-low one-hot row drive for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - free-running scan tick divider
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic iCLK,
    input  logic iRST_n,
    output logic tick
);

    localparam int             W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0]   TERM = W'(SCAN_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_tick;

    assign w_tick = (r_cnt == TERM);
    assign tick   = w_tick;

    // Count 0..SCAN_DIV-1 and restart; never paused so scan timing stays fixed.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner, debouncer and single-cycle key strobe
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [3:0]  iCOL,
    output logic [3:0]  oROW,
    output logic [15:0] key_num,
    output logic        oKey_down
);

    localparam int            CW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [3:0]        r_col_meta;
    logic [3:0]        r_col_s;
    state_t            r_state;
    logic [1:0]        r_row;
    logic [CODE_W-1:0] r_code;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_rcnt;

    logic              w_tick;
    logic              w_key;
    logic [CODE_W-1:0] w_code;
    logic [1:0]        w_row_next;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .tick   (w_tick)
    );

    assign w_key      = (r_col_s != 4'hF);
    assign w_code     = key_code(r_row, r_col_s);
    assign w_row_next = r_row + 2'd1;

    // Two-flop synchroniser for the asynchronous, active-low column returns.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= iCOL;
            r_col_s    <= r_col_meta;
        end
    end

    // Scan/debounce/emit/hold FSM; every output is a register updated here.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state   <= SCAN;
            r_row     <= 2'd0;
            oROW      <= 4'b1110;
            r_code    <= '0;
            r_cnt     <= '0;
            r_rcnt    <= '0;
            key_num   <= KEY_IDLE;
            oKey_down <= 1'b0;
        end else begin
            key_num <= KEY_IDLE;
            case (r_state)
                SCAN: begin
                    if (w_tick) begin
                        if (w_key) begin
                            r_code  <= w_code;
                            r_cnt   <= '0;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_row <= w_row_next;
                            oROW  <= row_drive(w_row_next);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_tick) begin
                        if (w_key && (w_code == r_code)) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == DB_LAST) begin
                                r_state   <= EMIT;
                                key_num   <= key_strobe(r_code);
                                oKey_down <= 1'b1;
                            end
                        end else begin
                            r_state <= SCAN;
                            r_row   <= w_row_next;
                            oROW    <= row_drive(w_row_next);
                        end
                    end
                end
                EMIT: begin
                    r_rcnt  <= '0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    // Any column activity, even another key, restarts the release count.
                    if (w_tick) begin
                        if (!w_key) begin
                            r_rcnt <= r_rcnt + 1'b1;
                            if (r_rcnt == DB_LAST) begin
                                r_state   <= SCAN;
                                oKey_down <= 1'b0;
                                r_row     <= w_row_next;
                                oROW      <= row_drive(w_row_next);
                            end
                        end else begin
                            r_rcnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan with a keypad matrix model
module tb_keypad_scan;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        iCLK;
    logic        iRST_n;
    logic [3:0]  iCOL;
    logic [3:0]  oROW;
    logic [15:0] key_num;
    logic        oKey_down;

    logic [15:0] keys;
    int          cyc;
    int          n_tests;
    int          n_fail;
    exp_t        q[$];

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iCOL      (iCOL),
        .oROW      (oROW),
        .key_num   (key_num),
        .oKey_down (oKey_down)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        iCOL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !oROW[r]) iCOL[c] = 1'b0;
            end
        end
    end

    // Cycle index since reset release: after posedge n, cyc == n.
    always @(posedge iCLK) begin
        if (!iRST_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: row drive stays one-hot low; every strobe is matched against the queue.
    always @(negedge iCLK) begin
        if (iRST_n === 1'b1) begin
            chk("row_onehot", 32'($countones(~oROW)), 32'd1);
            if (key_num !== 16'h00FF) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_strobe: got key_num %h at cyc %0d, expected none", key_num, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_value", 32'(key_num), 32'(e.val));
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge iCLK);
    endtask

    task automatic expect_strobe(input logic [15:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge iCLK);
        iRST_n = 1'b0;
        keys   = k;
        #1;
        chk("rst_row", 32'(oROW), 32'h0000000E);
        chk("rst_key_num", 32'(key_num), 32'h000000FF);
        chk("rst_key_down", 32'(oKey_down), 32'd0);
        q.delete();
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        keys    = '0;
        iRST_n  = 1'b0;

        // Reset values and idle row rotation, one step per 4 cycles.
        do_reset(16'h0000);
        for (int n = 1; n <= 17; n++) begin
            logic [3:0] exp_row;
            wait_cyc(n);
            exp_row = ~(4'b0001 << ((n / 4) % 4));
            chk("idle_rotation", 32'(oROW), 32'(exp_row));
        end
        wait_cyc(30);
        chk("t1_q_empty", 32'(q.size()), 32'd0);

        // Clean S5 press: detect on tick at edge 8, strobe at cyc 20, release at 200.
        do_reset(16'h0010);
        expect_strobe(16'h8004, 20);
        wait_cyc(19);  chk("t2_down_pre", 32'(oKey_down), 32'd0);
        wait_cyc(20);  chk("t2_down_emit", 32'(oKey_down), 32'd1);
        wait_cyc(200); keys = 16'h0000;
        wait_cyc(211); chk("t2_down_hold", 32'(oKey_down), 32'd1);
        wait_cyc(212); chk("t2_down_rel", 32'(oKey_down), 32'd0);
        wait_cyc(240);
        chk("t2_q_empty", 32'(q.size()), 32'd0);

        // Bounce on S6: abort at tick 16, re-press rescans to row 1 and strobes at 44.
        do_reset(16'h0020);
        wait_cyc(13);  keys = 16'h0000;
        wait_cyc(20);  keys = 16'h0020;
        expect_strobe(16'h8005, 44);
        wait_cyc(100); keys = 16'h0000;
        wait_cyc(130);
        chk("t3_q_empty", 32'(q.size()), 32'd0);

        // Two keys in row 0 (cols 1 and 3): lowest code wins.
        do_reset(16'h000A);
        expect_strobe(16'h8001, 16);
        wait_cyc(60);  keys = 16'h0000;
        wait_cyc(100);
        chk("t4_q_empty", 32'(q.size()), 32'd0);

        // Hold S1, tap S2 in HOLD, then a bouncy release restarts the release count.
        do_reset(16'h0001);
        expect_strobe(16'h8000, 16);
        wait_cyc(30);  keys = 16'h0003;
        wait_cyc(50);  keys = 16'h0001;
        wait_cyc(60);  keys = 16'h0000;
        wait_cyc(69);  keys = 16'h0001;
        wait_cyc(73);  keys = 16'h0000;
        wait_cyc(79);  chk("t5_down_restart", 32'(oKey_down), 32'd1);
        wait_cyc(83);  chk("t5_down_late", 32'(oKey_down), 32'd1);
        wait_cyc(84);  chk("t5_down_rel", 32'(oKey_down), 32'd0);
        wait_cyc(120);
        chk("t5_q_empty", 32'(q.size()), 32'd0);

        // Reset in DEBOUNCE, then in HOLD, with S5 held; each restart strobes once.
        do_reset(16'h0010);
        wait_cyc(10);
        chk("t6_q_empty_deb", 32'(q.size()), 32'd0);
        do_reset(16'h0010);
        expect_strobe(16'h8004, 20);
        wait_cyc(40);
        chk("t6_down_hold", 32'(oKey_down), 32'd1);
        chk("t6_q_empty_hold", 32'(q.size()), 32'd0);
        do_reset(16'h0010);
        expect_strobe(16'h8004, 20);
        wait_cyc(50);  keys = 16'h0000;
        wait_cyc(80);
        chk("t6_q_empty_end", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
